// File: rtl/dmem_responder.sv
// Data-memory responder for MEM-stage load/store requests, one access outstanding at a time.
// Latency: rvalid_o pulses LATENCY cycles after accept; rdata_o/err_o register on the edge entering RESP.
// Backpressure: ready_o low from accept until the RESP cycle ends; requests seen while not ready are dropped, never queued.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            accept;
    logic            enter_resp;
    logic            in_err;

    logic            lat_we_q;
    logic            lat_err_q;
    logic [AW-1:0]   lat_idx_q;
    logic [31:0]     lat_wdata_q;
    logic [3:0]      lat_be_q;

    logic            cur_we;
    logic            cur_err;
    logic [AW-1:0]   cur_idx;
    logic [31:0]     cur_wdata;
    logic [3:0]      cur_be;
    logic            mem_we;

    logic [31:0]     mem [DEPTH_WORDS];

    assign ready_o  = (state_q == IDLE);
    assign rvalid_o = (state_q == RESP);
    assign stall_o  = (state_q != IDLE);
    assign accept   = req_i & ready_o;

    assign in_err = (addr_i[1:0] != 2'b00) |
                    ({2'b00, addr_i[31:2]} >= 32'(DEPTH_WORDS));

    // With LATENCY=1 the edge entering RESP is the accept edge, so the live
    // inputs stand in for the not-yet-latched request.
    assign cur_we    = ready_o ? we_i              : lat_we_q;
    assign cur_err   = ready_o ? in_err            : lat_err_q;
    assign cur_idx   = ready_o ? addr_i[AW+1:2]    : lat_idx_q;
    assign cur_wdata = ready_o ? wdata_i           : lat_wdata_q;
    assign cur_be    = ready_o ? be_i              : lat_be_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            lat_we_q    <= 1'b0;
            lat_err_q   <= 1'b0;
            lat_idx_q   <= '0;
            lat_wdata_q <= 32'd0;
            lat_be_q    <= 4'd0;
            rdata_o     <= 32'd0;
            err_o       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                lat_we_q    <= we_i;
                lat_err_q   <= in_err;
                lat_idx_q   <= addr_i[AW+1:2];
                lat_wdata_q <= wdata_i;
                lat_be_q    <= be_i;
            end
            if (enter_resp) begin
                err_o   <= cur_err;
                rdata_o <= (cur_we | cur_err) ? 32'd0 : mem[cur_idx];
            end
        end
    end

    // Gating with rst_i guarantees a store caught by reset never lands.
    assign mem_we = rst_i & enter_resp & cur_we & ~cur_err;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

endmodule
